health_round_manager: RTL and testbench

Parametrised successor to the two-player health tracker. Owns both players' health, applies melee and projectile damage with fixed priority, and enforces per-player invincibility frames. Detects KO and double-KO, counts round wins and runs a best-of-N match state machine with an automatic inter-round hold. Sits between the hit-detection/attack logic and the HUD/game-flow logic.

---
 rtl/health_round_manager.sv | 189 ++++++++++++++++++
 tb/tb_health_round_manager.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/health_round_manager.sv
// Purpose: two-player health, damage arbitration, invincibility frames, KO/DRAW
//          detection, round-win counting and a best-of-N match state machine.
// Ports:   clk, reset (async, active-low)
//          in_range, attack_state_1/2, bullet_hit_1/2 : damage sources
//          new_match                                  : restart from MATCH_P1/MATCH_P2
//          health_1/2, state, hit1/2, invuln_1/2, wins_1/2, round_start : registered status
// Option:  `define BLOCK_EN adds block_1/block_2; a blocked melee hit deals DMG>>2.
module health_round_manager #(
    parameter int unsigned HP_MAX         = 400,
    parameter int unsigned HP_W           = 9,
    parameter int unsigned DMG_LIGHT      = 5,
    parameter int unsigned DMG_HEAVY      = 10,
    parameter int unsigned DMG_BULLET     = 15,
    parameter int unsigned IFRAME_CYCLES  = 30,
    parameter int unsigned KO_HOLD_CYCLES = 100,
    parameter int unsigned ROUNDS_TO_WIN  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_range,
    input  logic [1:0]      attack_state_1,
    input  logic [1:0]      attack_state_2,
    input  logic            bullet_hit_1,
    input  logic            bullet_hit_2,
    input  logic            new_match,
`ifdef BLOCK_EN
    input  logic            block_1,
    input  logic            block_2,
`endif
    output logic [HP_W-1:0] health_1,
    output logic [HP_W-1:0] health_2,
    output logic [2:0]      state,
    output logic            hit1,
    output logic            hit2,
    output logic            invuln_1,
    output logic            invuln_2,
    output logic [1:0]      wins_1,
    output logic [1:0]      wins_2,
    output logic            round_start
);

    localparam int unsigned IF_W      = (IFRAME_CYCLES > 0) ? $clog2(IFRAME_CYCLES + 1) : 1;
    localparam int unsigned HOLD_W    = (KO_HOLD_CYCLES > 1) ? $clog2(KO_HOLD_CYCLES) : 1;
    localparam int unsigned HOLD_LAST = (KO_HOLD_CYCLES > 0) ? KO_HOLD_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        FIGHT    = 3'b000,
        KO_P1    = 3'b001,
        KO_P2    = 3'b010,
        DRAW     = 3'b011,
        MATCH_P1 = 3'b101,
        MATCH_P2 = 3'b110
    } state_t;

    state_t            st;
    logic [IF_W-1:0]   if_cnt_1, if_cnt_2, if_nxt_1, if_nxt_2;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HP_W-1:0]   dmg_1, dmg_2, nh_1, nh_2;
    logic              dv_1, dv_2, take_1, take_2;
    logic [1:0]        w1_inc, w2_inc;

    assign state = st;

    // Damage selection: bullet beats heavy beats light; P1 is hit by P2's attack.
    always_comb begin
        dmg_1 = '0;
        dv_1  = 1'b0;
        dmg_2 = '0;
        dv_2  = 1'b0;
        if (bullet_hit_1) begin
            dmg_1 = HP_W'(DMG_BULLET);
            dv_1  = 1'b1;
        end else if (in_range && attack_state_2 == 2'b10) begin
            dmg_1 = HP_W'(DMG_HEAVY);
            dv_1  = 1'b1;
        end else if (in_range && attack_state_2 == 2'b01) begin
            dmg_1 = HP_W'(DMG_LIGHT);
            dv_1  = 1'b1;
        end
        if (bullet_hit_2) begin
            dmg_2 = HP_W'(DMG_BULLET);
            dv_2  = 1'b1;
        end else if (in_range && attack_state_1 == 2'b10) begin
            dmg_2 = HP_W'(DMG_HEAVY);
            dv_2  = 1'b1;
        end else if (in_range && attack_state_1 == 2'b01) begin
            dmg_2 = HP_W'(DMG_LIGHT);
            dv_2  = 1'b1;
        end
`ifdef BLOCK_EN
        // Blocking only softens melee; bullets pass through at full damage.
        if (block_1 && !bullet_hit_1) dmg_1 = dmg_1 >> 2;
        if (block_2 && !bullet_hit_2) dmg_2 = dmg_2 >> 2;
`endif
    end

    // Hit acceptance, saturating health update and iframe countdown.
    always_comb begin
        take_1   = (st == FIGHT) && (health_1 != '0) && (if_cnt_1 == '0) && dv_1;
        take_2   = (st == FIGHT) && (health_2 != '0) && (if_cnt_2 == '0) && dv_2;
        nh_1     = health_1;
        nh_2     = health_2;
        if (take_1) nh_1 = (health_1 > dmg_1) ? health_1 - dmg_1 : '0;
        if (take_2) nh_2 = (health_2 > dmg_2) ? health_2 - dmg_2 : '0;
        if_nxt_1 = (if_cnt_1 != '0) ? if_cnt_1 - IF_W'(1) : '0;
        if_nxt_2 = (if_cnt_2 != '0) ? if_cnt_2 - IF_W'(1) : '0;
        if (take_1) if_nxt_1 = IF_W'(IFRAME_CYCLES);
        if (take_2) if_nxt_2 = IF_W'(IFRAME_CYCLES);
        w1_inc   = wins_1 + 2'd1;
        w2_inc   = wins_2 + 2'd1;
    end

    // Round/match state machine with all status outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= FIGHT;
            health_1    <= HP_W'(HP_MAX);
            health_2    <= HP_W'(HP_MAX);
            hit1        <= 1'b0;
            hit2        <= 1'b0;
            if_cnt_1    <= '0;
            if_cnt_2    <= '0;
            invuln_1    <= 1'b0;
            invuln_2    <= 1'b0;
            wins_1      <= 2'd0;
            wins_2      <= 2'd0;
            hold_cnt    <= '0;
            round_start <= 1'b0;
        end else begin
            hit1        <= 1'b0;
            hit2        <= 1'b0;
            round_start <= 1'b0;
            if_cnt_1    <= if_nxt_1;
            if_cnt_2    <= if_nxt_2;
            invuln_1    <= (if_nxt_1 != '0);
            invuln_2    <= (if_nxt_2 != '0);
            case (st)
                FIGHT: begin
                    health_1 <= nh_1;
                    health_2 <= nh_2;
                    hit1     <= take_1;
                    hit2     <= take_2;
                    hold_cnt <= '0;
                    // KO is judged on the post-hit health of this same edge.
                    if (nh_1 == '0 && nh_2 == '0) begin
                        st <= DRAW;
                    end else if (nh_2 == '0) begin
                        wins_1 <= w1_inc;
                        st     <= (w1_inc == 2'(ROUNDS_TO_WIN)) ? MATCH_P1 : KO_P1;
                    end else if (nh_1 == '0) begin
                        wins_2 <= w2_inc;
                        st     <= (w2_inc == 2'(ROUNDS_TO_WIN)) ? MATCH_P2 : KO_P2;
                    end
                end
                KO_P1, KO_P2, DRAW: begin
                    if (hold_cnt == HOLD_W'(HOLD_LAST)) begin
                        st          <= FIGHT;
                        hold_cnt    <= '0;
                        health_1    <= HP_W'(HP_MAX);
                        health_2    <= HP_W'(HP_MAX);
                        if_cnt_1    <= '0;
                        if_cnt_2    <= '0;
                        invuln_1    <= 1'b0;
                        invuln_2    <= 1'b0;
                        round_start <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                default: begin
                    // MATCH_P1 / MATCH_P2: frozen until a new match is requested.
                    if (new_match) begin
                        st          <= FIGHT;
                        wins_1      <= 2'd0;
                        wins_2      <= 2'd0;
                        health_1    <= HP_W'(HP_MAX);
                        health_2    <= HP_W'(HP_MAX);
                        if_cnt_1    <= '0;
                        if_cnt_2    <= '0;
                        invuln_1    <= 1'b0;
                        invuln_2    <= 1'b0;
                        round_start <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_health_round_manager.sv
// Directed bench: instance a uses default parameters (iframes), instance b uses
// HP_MAX=42 and IFRAME_CYCLES=0 for KO, DRAW, match and async-reset scenarios.
module tb_health_round_manager;

    logic clk;
    logic reset;

    logic       a_ir, a_bh1, a_bh2, a_nm;
    logic [1:0] a_atk1, a_atk2;
    logic [8:0] a_h1, a_h2;
    logic [2:0] a_state;
    logic       a_hit1, a_hit2, a_inv1, a_inv2, a_rs;
    logic [1:0] a_w1, a_w2;

    logic       b_ir, b_bh1, b_bh2, b_nm;
    logic [1:0] b_atk1, b_atk2;
    logic [8:0] b_h1, b_h2;
    logic [2:0] b_state;
    logic       b_hit1, b_hit2, b_inv1, b_inv2, b_rs;
    logic [1:0] b_w1, b_w2;

    int checks = 0;
    int passes = 0;

    health_round_manager u_a (
        .clk(clk), .reset(reset), .in_range(a_ir),
        .attack_state_1(a_atk1), .attack_state_2(a_atk2),
        .bullet_hit_1(a_bh1), .bullet_hit_2(a_bh2), .new_match(a_nm),
`ifdef BLOCK_EN
        .block_1(1'b0), .block_2(1'b0),
`endif
        .health_1(a_h1), .health_2(a_h2), .state(a_state),
        .hit1(a_hit1), .hit2(a_hit2), .invuln_1(a_inv1), .invuln_2(a_inv2),
        .wins_1(a_w1), .wins_2(a_w2), .round_start(a_rs)
    );

    health_round_manager #(.HP_MAX(42), .IFRAME_CYCLES(0)) u_b (
        .clk(clk), .reset(reset), .in_range(b_ir),
        .attack_state_1(b_atk1), .attack_state_2(b_atk2),
        .bullet_hit_1(b_bh1), .bullet_hit_2(b_bh2), .new_match(b_nm),
`ifdef BLOCK_EN
        .block_1(1'b0), .block_2(1'b0),
`endif
        .health_1(b_h1), .health_2(b_h2), .state(b_state),
        .hit1(b_hit1), .hit2(b_hit2), .invuln_1(b_inv1), .invuln_2(b_inv2),
        .wins_1(b_w1), .wins_2(b_w2), .round_start(b_rs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_inputs();
        a_ir = 0; a_bh1 = 0; a_bh2 = 0; a_nm = 0; a_atk1 = 2'b00; a_atk2 = 2'b00;
        b_ir = 0; b_bh1 = 0; b_bh2 = 0; b_nm = 0; b_atk1 = 2'b00; b_atk2 = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        idle(2);
        checks++; if (a_h1 !== 9'd400 || a_h2 !== 9'd400) $display("FAIL reset_health_a: got %0d/%0d want 400/400", a_h1, a_h2); else passes++;
        checks++; if (b_h1 !== 9'd42 || b_h2 !== 9'd42) $display("FAIL reset_health_b: got %0d/%0d want 42/42", b_h1, b_h2); else passes++;
        checks++; if ({a_state, a_w1, a_w2, a_hit1, a_hit2, a_inv1, a_inv2, a_rs} !== 12'd0)
            $display("FAIL reset_status_a: got state=%0d w=%0d/%0d hit=%b%b inv=%b%b rs=%b want all 0",
                     a_state, a_w1, a_w2, a_hit1, a_hit2, a_inv1, a_inv2, a_rs); else passes++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_heavy_iframe();
        int n;
        a_ir = 1; a_atk1 = 2'b10;
        tick();
        clear_inputs();
        checks++; if (a_h2 !== 9'd390) $display("FAIL heavy_health2: got %0d want 390", a_h2); else passes++;
        checks++; if (a_hit2 !== 1'b1 || a_inv2 !== 1'b1) $display("FAIL heavy_hit_inv: got hit2=%b inv2=%b want 1/1", a_hit2, a_inv2); else passes++;
        checks++; if (a_h1 !== 9'd400 || a_hit1 !== 1'b0) $display("FAIL heavy_p1_untouched: got %0d hit1=%b want 400/0", a_h1, a_hit1); else passes++;
        n = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 0) begin
                checks++; if (a_hit2 !== 1'b0) $display("FAIL hit2_pulse_width: got %b want 0", a_hit2); else passes++;
            end
            if (!a_inv2) break;
            n++;
        end
        checks++; if (n != 30) $display("FAIL iframe_length: got %0d want 30", n); else passes++;
    endtask

    task automatic test_priority_iframe_drop();
        a_bh2 = 1; a_ir = 1; a_atk1 = 2'b10;
        tick();
        clear_inputs();
        checks++; if (a_h2 !== 9'd375 || a_hit2 !== 1'b1) $display("FAIL priority_bullet: got %0d hit2=%b want 375/1", a_h2, a_hit2); else passes++;
        idle(9);
        a_bh2 = 1;
        tick();
        clear_inputs();
        checks++; if (a_h2 !== 9'd375 || a_hit2 !== 1'b0) $display("FAIL iframe_drop: got %0d hit2=%b want 375/0", a_h2, a_hit2); else passes++;
        idle(20);
        a_bh2 = 1;
        tick();
        clear_inputs();
        checks++; if (a_h2 !== 9'd360 || a_hit2 !== 1'b1) $display("FAIL iframe_expired_hit: got %0d hit2=%b want 360/1", a_h2, a_hit2); else passes++;
        checks++; if (a_h1 !== 9'd400) $display("FAIL priority_p1: got %0d want 400", a_h1); else passes++;
    endtask

    task automatic test_both_melee();
        idle(31);
        a_ir = 1; a_atk1 = 2'b01; a_atk2 = 2'b10;
        tick();
        clear_inputs();
        checks++; if (a_h2 !== 9'd355 || a_h1 !== 9'd390) $display("FAIL both_melee_health: got %0d/%0d want 390/355", a_h1, a_h2); else passes++;
        checks++; if (a_hit1 !== 1'b1 || a_hit2 !== 1'b1) $display("FAIL both_melee_hits: got %b%b want 11", a_hit1, a_hit2); else passes++;
        idle(31);
        a_ir = 1; a_atk1 = 2'b11;
        tick();
        clear_inputs();
        checks++; if (a_h2 !== 9'd355 || a_hit2 !== 1'b0) $display("FAIL attack_11_ignored: got %0d hit2=%b want 355/0", a_h2, a_hit2); else passes++;
        a_atk1 = 2'b10;
        tick();
        clear_inputs();
        checks++; if (a_h2 !== 9'd355 || a_hit2 !== 1'b0) $display("FAIL out_of_range_ignored: got %0d hit2=%b want 355/0", a_h2, a_hit2); else passes++;
    endtask

    task automatic test_ko_hold();
        int n;
        b_bh2 = 1;
        tick();
        checks++; if (b_h2 !== 9'd27 || b_hit2 !== 1'b1) $display("FAIL b2b_first: got %0d hit2=%b want 27/1", b_h2, b_hit2); else passes++;
        tick();
        checks++; if (b_h2 !== 9'd12 || b_hit2 !== 1'b1) $display("FAIL b2b_second: got %0d hit2=%b want 12/1", b_h2, b_hit2); else passes++;
        tick();
        clear_inputs();
        checks++; if (b_h2 !== 9'd0 || b_state !== 3'b001 || b_w1 !== 2'd1)
            $display("FAIL ko_p1_entry: got h2=%0d state=%0d w1=%0d want 0/1/1", b_h2, b_state, b_w1); else passes++;
        b_bh1 = 1;
        tick();
        clear_inputs();
        checks++; if (b_h1 !== 9'd42 || b_hit1 !== 1'b0) $display("FAIL ko_no_damage: got %0d hit1=%b want 42/0", b_h1, b_hit1); else passes++;
        n = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            n++;
            if (b_rs) break;
        end
        checks++; if (n != 100) $display("FAIL ko_hold_length: got %0d want 100", n); else passes++;
        checks++; if (b_state !== 3'b000 || b_h1 !== 9'd42 || b_h2 !== 9'd42 || b_w1 !== 2'd1)
            $display("FAIL round_restart: got state=%0d h=%0d/%0d w1=%0d want 0 42/42 1", b_state, b_h1, b_h2, b_w1); else passes++;
        tick();
        checks++; if (b_rs !== 1'b0) $display("FAIL round_start_pulse: got %b want 0", b_rs); else passes++;
    endtask

    task automatic test_draw();
        bit seen;
        b_bh1 = 1; b_bh2 = 1;
        idle(3);
        clear_inputs();
        checks++; if (b_h1 !== 9'd0 || b_h2 !== 9'd0 || b_state !== 3'b011)
            $display("FAIL draw_entry: got h=%0d/%0d state=%0d want 0/0/3", b_h1, b_h2, b_state); else passes++;
        checks++; if (b_w1 !== 2'd1 || b_w2 !== 2'd0) $display("FAIL draw_wins: got %0d/%0d want 1/0", b_w1, b_w2); else passes++;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (b_rs) begin seen = 1; break; end
        end
        checks++; if (!seen || b_state !== 3'b000 || b_h1 !== 9'd42)
            $display("FAIL draw_restart: got seen=%b state=%0d h1=%0d want 1/0/42", seen, b_state, b_h1); else passes++;
    endtask

    task automatic test_match();
        b_nm = 1;
        tick();
        clear_inputs();
        checks++; if (b_w1 !== 2'd1 || b_state !== 3'b000) $display("FAIL new_match_ignored: got w1=%0d state=%0d want 1/0", b_w1, b_state); else passes++;
        b_bh2 = 1;
        idle(3);
        clear_inputs();
        checks++; if (b_state !== 3'b101 || b_w1 !== 2'd2) $display("FAIL match_p1_entry: got state=%0d w1=%0d want 5/2", b_state, b_w1); else passes++;
        b_bh1 = 1;
        idle(5);
        clear_inputs();
        checks++; if (b_state !== 3'b101 || b_h1 !== 9'd42 || b_hit1 !== 1'b0)
            $display("FAIL match_frozen: got state=%0d h1=%0d hit1=%b want 5/42/0", b_state, b_h1, b_hit1); else passes++;
        b_nm = 1;
        tick();
        clear_inputs();
        checks++; if (b_state !== 3'b000 || b_w1 !== 2'd0 || b_h1 !== 9'd42 || b_h2 !== 9'd42 || b_rs !== 1'b1)
            $display("FAIL new_match_restart: got state=%0d w1=%0d h=%0d/%0d rs=%b want 0/0 42/42 1",
                     b_state, b_w1, b_h1, b_h2, b_rs); else passes++;
    endtask

    task automatic test_async_reset();
        b_bh2 = 1;
        idle(3);
        clear_inputs();
        idle(20);
        checks++; if (b_state !== 3'b001) $display("FAIL pre_reset_ko: got state=%0d want 1", b_state); else passes++;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (b_state !== 3'b000 || b_w1 !== 2'd0 || b_h2 !== 9'd42 || b_rs !== 1'b0)
            $display("FAIL async_reset_b: got state=%0d w1=%0d h2=%0d rs=%b want 0/0/42/0", b_state, b_w1, b_h2, b_rs); else passes++;
        checks++; if (a_h1 !== 9'd400 || a_h2 !== 9'd400) $display("FAIL async_reset_a: got %0d/%0d want 400/400", a_h1, a_h2); else passes++;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_heavy_iframe();
        test_priority_iframe_drop();
        test_both_melee();
        test_ko_hold();
        test_draw();
        test_match();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
